ps2_keycode_writer: RTL and testbench
=====================================

// Module: ps2_keycode_writer
// PURPOSE
//  Receives PS/2 keyboard frames and decodes make/break/E0 scan-code sequences.
//  Maps supported keys to a 5-bit game key code.
//  Writes {code, pressed} into the instruction-memory patch port as keyboard[5:0],
//  qualified by a one-cycle WriteEnable. This is the producer end of the keyboard
//  path into instruction memory.
// PARAMETERS
//  FILTER_LEN     8      CLK cycles ps2_clk must be stable before a level change is accepted
//  TIMEOUT_CYCLES 50000  idle CLK cycles inside a frame before the frame is discarded (~1 ms @50 MHz)
// PORTS
//  CLK          in   1  system clock, all logic on posedge
//  Reset        in   1  synchronous, active-high reset
//  ps2_clk      in   1  raw PS/2 clock from keyboard (asynchronous)
//  ps2_data     in   1  raw PS/2 data from keyboard (asynchronous)
//  keyboard     out  6  [5:1] key code, [0] pressed flag; registered
//  WriteEnable  out  1  one-cycle strobe; keyboard is valid in the same cycle
//  frame_error  out  1  one-cycle strobe on parity, start, stop or timeout error
// BEHAVIOUR
//  Reset: keyboard=6'd0, WriteEnable=0, frame_error=0, both FSMs idle, E0/F0 flags clear,
//   held-code register=0. Reset mid-frame discards all partial state.
//  Input conditioning:
//   - ps2_clk and ps2_data each pass a 2-FF synchronizer.
//   - ps2_clk then passes a FILTER_LEN stability filter.
//   - A falling edge of the filtered clock samples synchronized data.
//  Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE, one state step per falling edge.
//   - IDLE: data=0 -> DATA, bit counter=0. data=1 -> frame_error, stay in IDLE.
//   - DATA: shift LSB first; after the 8th bit -> PARITY.
//   - PARITY: require odd parity over 8 data bits plus the parity bit.
//   - STOP: require data=1. On success, present a byte_valid strobe to the decoder.
//   - Any check failure: frame_error pulse, byte dropped, return to IDLE.
//   - Timeout: TIMEOUT_CYCLES without a falling edge while not IDLE -> frame_error, IDLE.
//  Decoder (per valid byte):
//   - 0xE0 sets ext. 0xF0 sets brk. Any other byte is a final byte.
//   - A final byte is looked up with ext; ext and brk clear after every final byte.
//   - Make of mapped key K, K != held code, or pressed=0:
//     keyboard<={K,1}, held<=K, WriteEnable=1 for one cycle.
//   - Make of K == held while pressed=1 (typematic repeat): no write.
//   - Break of K == held while pressed=1: keyboard<={K,0}, WriteEnable=1 for one cycle.
//   - Break of any other key: no write.
//   - Unmapped final byte: no write; flags still clear.
//  Latency: WriteEnable is asserted 1 CLK after the STOP-bit sample edge is detected.
//   keyboard and WriteEnable update on the same edge. The consumer latches on the
//   following negedge.
//  WriteEnable is never asserted two consecutive cycles; new bytes arrive >=30 us apart.
//  A byte completing in the same cycle as Reset is discarded; Reset wins.
//  Key map (code, 5 bits):
//   Up/W=3, Down/S=4, Left/A=5, Right/D=6, Enter=0x16, Esc=0x1E, Space=0x1F, all others unmapped.
//   Arrows require ext=1. Letter keys require ext=0.
// STRUCTURE
//  Shared package: KEY_* 5-bit code constants, PS2_EXT=8'hE0, PS2_BRK=8'hF0, frame FSM
//   state encodings. The package is shared with the memory/CPU side.
//  Sub-module ps2_scancode_map: combinational {ext, scancode[7:0]} -> {mapped, code[4:0]}.
//  Top level holds: synchronizers, filter, frame FSM, timeout counter, decoder flags,
//   output registers.
// TESTING
//  1 Frame 0x1D (W), valid odd parity -> single WriteEnable pulse, keyboard=6'b000111.
//  2 Sequence E0 75, then E0 75 again, then E0 F0 75 -> writes {3,1} then {3,0}.
//    The repeat make produces no pulse.
//  3 Frame with wrong parity bit -> frame_error pulse, no WriteEnable, keyboard unchanged.
//  4 Start bit, 4 data bits, then ps2_clk idle > TIMEOUT_CYCLES -> frame_error.
//    The next valid frame 0x29 (Space) -> {0x1F,1}.
//  5 Hold A (0x1C), press D (0x23), release A (F0 1C) -> writes {5,1}, {6,1}, then nothing.
//    A later F0 23 -> {6,0}.
//  6 Reset asserted during DATA of 0x5A, then a full 0x5A frame -> keyboard=0 after reset,
//    then {0x16,1}. A 1-cycle ps2_clk glitch < FILTER_LEN causes no bit shift.

Source files
------------

// File: rtl/ps2_keycode_writer_pkg.sv
// Shared keyboard-path definitions: game key codes, PS/2 prefix bytes,
// set-2 scan codes of the supported keys and the frame FSM states.
package ps2_keycode_writer_pkg;

  // 5-bit game key codes seen by the memory/CPU side
  localparam logic [4:0] KEY_UP    = 5'd3;
  localparam logic [4:0] KEY_DOWN  = 5'd4;
  localparam logic [4:0] KEY_LEFT  = 5'd5;
  localparam logic [4:0] KEY_RIGHT = 5'd6;
  localparam logic [4:0] KEY_ENTER = 5'h16;
  localparam logic [4:0] KEY_ESC   = 5'h1E;
  localparam logic [4:0] KEY_SPACE = 5'h1F;

  // PS/2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Set-2 scan codes, non-extended
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Set-2 scan codes, E0-extended
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Frame receiver states
  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_keycode_writer_scancode_map.sv
// Combinational scan-code lookup: {ext, scancode} -> {mapped, game code}.
// Arrows exist only as E0-extended codes; all other keys only without E0.
module ps2_scancode_map
  import ps2_keycode_writer_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] scancode,
  output logic       mapped,
  output logic [4:0] code
);

  // Table lookup, default unmapped
  always_comb begin
    mapped = 1'b0;
    code   = '0;
    if (ext) begin
      case (scancode)
        SC_UP:    begin mapped = 1'b1; code = KEY_UP;    end
        SC_DOWN:  begin mapped = 1'b1; code = KEY_DOWN;  end
        SC_LEFT:  begin mapped = 1'b1; code = KEY_LEFT;  end
        SC_RIGHT: begin mapped = 1'b1; code = KEY_RIGHT; end
        default:  begin mapped = 1'b0; code = '0;        end
      endcase
    end else begin
      case (scancode)
        SC_W:     begin mapped = 1'b1; code = KEY_UP;    end
        SC_S:     begin mapped = 1'b1; code = KEY_DOWN;  end
        SC_A:     begin mapped = 1'b1; code = KEY_LEFT;  end
        SC_D:     begin mapped = 1'b1; code = KEY_RIGHT; end
        SC_ENTER: begin mapped = 1'b1; code = KEY_ENTER; end
        SC_ESC:   begin mapped = 1'b1; code = KEY_ESC;   end
        SC_SPACE: begin mapped = 1'b1; code = KEY_SPACE; end
        default:  begin mapped = 1'b0; code = '0;        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode_writer.sv
// PS/2 keyboard receiver and key-event writer. Conditions the raw PS/2
// lines, deframes bytes, decodes E0/F0 sequences and writes
// {code, pressed} into the instruction-memory patch port.
module ps2_keycode_writer
  import ps2_keycode_writer_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] keyboard,
  output logic       WriteEnable,
  output logic       frame_error
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, clk_flt_d;
  logic          fall, sdata;

  frame_state_t  state, state_nx;
  logic [2:0]    bitcnt;
  logic [7:0]    shift_q;
  logic [TW-1:0] to_cnt;
  logic          timeout, parity_ok;
  logic          byte_valid, frame_err_c;

  logic          ext_flag, brk_flag;
  logic [4:0]    held;
  logic          map_hit;
  logic [4:0]    map_code;

  // Two-flop synchronizers; idle PS/2 lines are high
  always_ff @(posedge CLK) begin
    if (Reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Clock filter: accept a new level only after FILTER_LEN stable cycles
  always_ff @(posedge CLK) begin
    if (Reset) begin
      flt_cnt <= '0;
      clk_flt <= 1'b1;
    end else if (clk_sync[1] == clk_flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt_cnt <= '0;
      clk_flt <= clk_sync[1];
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // Previous filtered level for falling-edge detection
  always_ff @(posedge CLK) begin
    if (Reset) clk_flt_d <= 1'b1;
    else       clk_flt_d <= clk_flt;
  end

  assign fall      = clk_flt_d & ~clk_flt;
  assign sdata     = dat_sync[1];
  assign parity_ok = ^{shift_q, sdata};
  assign timeout   = (state != FR_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Frame FSM state register
  always_ff @(posedge CLK) begin
    if (Reset) state <= FR_IDLE;
    else       state <= state_nx;
  end

  // Frame FSM next state, one step per filtered falling edge
  always_comb begin
    state_nx = state;
    case (state)
      FR_IDLE:   if (fall && !sdata)           state_nx = FR_DATA;
      FR_DATA:   if (fall && bitcnt == 3'd7)   state_nx = FR_PARITY;
      FR_PARITY: if (fall)                     state_nx = parity_ok ? FR_STOP : FR_IDLE;
      FR_STOP:   if (fall)                     state_nx = FR_IDLE;
      default:                                 state_nx = FR_IDLE;
    endcase
    if (timeout) state_nx = FR_IDLE;
  end

  // Frame FSM outputs: byte strobe and error strobe
  always_comb begin
    byte_valid  = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      FR_IDLE:   frame_err_c = fall && sdata;
      FR_DATA:   frame_err_c = 1'b0;
      FR_PARITY: frame_err_c = fall && !parity_ok;
      FR_STOP: begin
        byte_valid  = fall && sdata;
        frame_err_c = fall && !sdata;
      end
      default:   frame_err_c = 1'b0;
    endcase
    if (timeout) frame_err_c = 1'b1;
  end

  // Frame datapath: bit counter, LSB-first shifter, inactivity counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      bitcnt  <= '0;
      shift_q <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == FR_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
      if (state == FR_IDLE && fall && !sdata) bitcnt <= '0;
      if (state == FR_DATA && fall) begin
        shift_q <= {sdata, shift_q[7:1]};
        bitcnt  <= bitcnt + 1'b1;
      end
    end
  end

  ps2_scancode_map u_map (
    .ext      (ext_flag),
    .scancode (shift_q),
    .mapped   (map_hit),
    .code     (map_code)
  );

  // Error strobe register
  always_ff @(posedge CLK) begin
    if (Reset) frame_error <= 1'b0;
    else       frame_error <= frame_err_c;
  end

  // Decoder: prefix flags, held key and the write port.
  // keyboard[0] doubles as the "held key is pressed" flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      held        <= '0;
      keyboard    <= '0;
      WriteEnable <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      if (byte_valid) begin
        if (shift_q == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (map_hit) begin
            if (!brk_flag) begin
              if (map_code != held || !keyboard[0]) begin
                keyboard    <= {map_code, 1'b1};
                held        <= map_code;
                WriteEnable <= 1'b1;
              end
            end else if (map_code == held && keyboard[0]) begin
              keyboard    <= {map_code, 1'b0};
              WriteEnable <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_writer.sv
// Self-checking bench: drives PS/2 frames, predicts key writes and frame
// errors with a byte-level model, and checks every write strobe.
module tb_ps2_keycode_writer;

  localparam int HALF = 20;   // CLK cycles per PS/2 half period
  localparam int GAP  = 80;   // idle CLK cycles between bytes
  localparam int TMO  = 200;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] keyboard;
  logic       WriteEnable;
  logic       frame_error;

  always #5 CLK = ~CLK;

  ps2_keycode_writer #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keyboard    (keyboard),
    .WriteEnable (WriteEnable),
    .frame_error (frame_error)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit ext; byte unsigned sc; int code; } keydef_t;
  keydef_t keys[$];   // code < 0 means unmapped

  logic [5:0] expq[$];
  logic [5:0] kb_exp  = '0;
  int         err_exp = 0;
  int         err_seen = 0;
  bit         m_ext, m_brk, m_pressed;
  int         m_held;

  function automatic int lookup(bit ext, byte unsigned sc);
    foreach (keys[i]) if (keys[i].ext == ext && keys[i].sc == sc) return keys[i].code;
    return -1;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_pressed = 0; m_held = 0;
    kb_exp = '0;
    expq.delete();
  endfunction

  function automatic void model_byte(byte unsigned b);
    int k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = lookup(m_ext, b);
      if (k >= 0) begin
        if (!m_brk) begin
          if (k != m_held || !m_pressed) begin
            expq.push_back({k[4:0], 1'b1});
            m_held = k; m_pressed = 1;
          end
        end else if (k == m_held && m_pressed) begin
          expq.push_back({k[4:0], 1'b0});
          m_pressed = 0;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // nbits < 11 sends a truncated frame; glitch_bit >= 0 puts a 1-cycle
  // low pulse on ps2_clk during the high phase before that bit's edge
  task automatic send_frame(input byte unsigned b, input bit bad_par,
                            input int glitch_bit, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11 && !bad_par) model_byte(b);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(HALF / 2);
        ps2_clk = 1'b0;
        @(negedge CLK);
        ps2_clk = 1'b1;
      end
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    @(negedge CLK);
    ps2_data = 1'b1;
    wait_cycles(GAP);
  endtask

  task automatic send_byte(input byte unsigned b);
    send_frame(b, 1'b0, -1, 11);
  endtask

  task automatic settle(input string tag);
    check({tag, "_pending"}, expq.size(), 0);
    check({tag, "_errors"}, err_seen, err_exp);
    check({tag, "_keyboard"}, keyboard, kb_exp);
  endtask

  // ---------------- compare process ----------------
  bit prev_we = 0;
  always @(negedge CLK) begin
    if (Reset) begin
      prev_we <= 0;
    end else begin
      if (frame_error) err_seen++;
      if (WriteEnable) begin
        check("we_gap", prev_we, 0);
        check("we_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          kb_exp = expq.pop_front();
          check("write_value", keyboard, kb_exp);
        end
      end
      prev_we <= WriteEnable;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    keys = '{
      '{0, 8'h1D, 3}, '{0, 8'h1B, 4}, '{0, 8'h1C, 5}, '{0, 8'h23, 6},
      '{0, 8'h5A, 'h16}, '{0, 8'h76, 'h1E}, '{0, 8'h29, 'h1F},
      '{1, 8'h75, 3}, '{1, 8'h72, 4}, '{1, 8'h6B, 5}, '{1, 8'h74, 6},
      '{1, 8'h1D, -1}, '{0, 8'h75, -1}, '{0, 8'h15, -1}, '{1, 8'h1C, -1}
    };
    model_reset();
    wait_cycles(5);
    Reset = 1'b0;
    @(negedge CLK);
    check("reset_keyboard", keyboard, 6'd0);
    check("reset_we", WriteEnable, 0);
    check("reset_ferr", frame_error, 0);
    wait_cycles(20);

    // W make
    send_byte(8'h1D);
    settle("w_make");
    check("w_literal", keyboard, 6'b000111);

    // Up arrow make, typematic repeat, break
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    settle("up_repeat");
    check("up_literal", keyboard, 6'b000111);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    settle("up_break");
    check("up_break_literal", keyboard, 6'b000110);

    // Bad parity: parity error, then the stop bit reads as a bad start bit
    send_frame(8'h1C, 1'b1, -1, 11);
    err_exp += 2;
    settle("bad_parity");
    check("bad_parity_literal", keyboard, 6'b000110);

    // Truncated frame, inactivity timeout, then Space
    send_frame(8'h29, 1'b0, -1, 5);
    wait_cycles(TMO + 50);
    err_exp += 1;
    settle("timeout");
    send_byte(8'h29);
    settle("space");
    check("space_literal", keyboard, 6'b111111);

    // Hold A, press D, release A (no write), release D
    send_byte(8'h1C);
    check("a_literal", keyboard, 6'b001011);
    send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1C);
    settle("a_d_release_a");
    check("d_literal", keyboard, 6'b001101);
    send_byte(8'hF0); send_byte(8'h23);
    settle("release_d");
    check("d_break_literal", keyboard, 6'b001100);

    // Reset mid-frame, then Enter with a short clock glitch inside the frame
    send_frame(8'h5A, 1'b0, -1, 4);
    Reset = 1'b1;
    wait_cycles(3);
    Reset = 1'b0;
    model_reset();
    @(negedge CLK);
    check("midframe_reset_keyboard", keyboard, 6'd0);
    wait_cycles(GAP);
    send_frame(8'h5A, 1'b0, 4, 11);
    settle("enter_glitch");
    check("enter_literal", keyboard, 6'b101101);

    // Randomized key events with occasional corrupted frames
    for (int n = 0; n < 40; n++) begin
      int idx;
      bit brk;
      idx = $urandom_range(keys.size() - 1);
      brk = $urandom_range(1);
      if ($urandom_range(7) == 0) begin
        send_frame(8'($urandom_range(255)), 1'b1, -1, 11);
        err_exp += 2;
      end
      if (keys[idx].ext) send_byte(8'hE0);
      if (brk) send_byte(8'hF0);
      send_byte(keys[idx].sc);
      settle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #(10 * 95000);
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
